mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter and sequencer that shares one single-port `Memory` between `NREQ` requesters (fetch unit, stack, I/O, debug port). It grants the memory to one requester at a time and drives `re`, `we` and `addr` for a fixed-length access cycle. It returns read data and a completion pulse, and supports bounded locked bursts. The write data path (`mem_wdata`) feeds the `BusDriver` that sits in front of `Memory.data`.

## Interface
- `NREQ`, 4: number of requesters (≥2)
- `AW`, 8: address width
- `DW`, 16: data width
- `LOCKMAX`, 4: maximum consecutive transactions per locked grant (≥1)

- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req`  in  NREQ  per-requester request
- `write`  in  NREQ  per-requester direction: 1 = write, 0 = read
- `lock`  in  NREQ  requests burst retention of the grant
- `addr`  in  NREQ*AW  flattened addresses; requester i at `[i*AW +: AW]`
- `wdata`  in  NREQ*DW  flattened write data; requester i at `[i*DW +: DW]`
- `gnt`  out  NREQ  one-hot grant, all-zero when idle
- `done`  out  NREQ  one-cycle completion pulse to the owner
- `rdata`  out  DW  registered read data
- `mem_re`  out  1  to `Memory.re`
- `mem_we`  out  1  to `Memory.we` and `BusDriver.en`
- `mem_addr`  out  AW  to `Memory.addr`
- `mem_wdata`  out  DW  to `BusDriver.data`
- `mem_rdata`  in  DW  from `BusDriver.buff`

## Operation
- **States:** IDLE, ACCESS, DONE. Registers:
  - `owner`: index, log2 NREQ bits
  - `last`: round-robin pointer
  - `burst`: count, 0..LOCKMAX-1
  - `gnt`, `done`, `rdata`
- **Reset values:**
  - state IDLE, `gnt`=0, `done`=0, `rdata`=0, `burst`=0
  - `last`=NREQ-1, so requester 0 has first priority
  - `mem_re`=`mem_we`=0, `mem_addr`=0, `mem_wdata`=0
- **IDLE:**
  - If no `req` bit is set, stay in IDLE.
  - Otherwise the winner is the first set `req` bit scanning `last+1, last+2, …` modulo NREQ.
  - Set `owner` to the winner, `gnt` to one-hot(winner), `burst` to 0, and go to ACCESS.
- **ACCESS (one cycle):**
  - Memory outputs are combinational from `owner`: `mem_addr=addr[owner]`, `mem_we=write[owner]`, `mem_re=~write[owner]`, `mem_wdata=wdata[owner]`.
  - The memory write commits on the edge that ends ACCESS.
  - On a read, `rdata` captures `mem_rdata` on that same edge.
  - Go to DONE.
- **Outside ACCESS:** `mem_re`=`mem_we`=0, and `mem_addr`/`mem_wdata` are 0.
- **DONE:**
  - `done[owner]`=1 for exactly this cycle. `gnt` stays held.
  - If `lock[owner] && req[owner] && burst<LOCKMAX-1`: increment `burst`, go to ACCESS, `gnt` unchanged.
  - Otherwise: `last` ← `owner`, `gnt` ← 0, go to IDLE.
- **`rdata`:** holds its value until the next read completes. Writes leave it unchanged.
- **Requester protocol:** hold `req`, `write`, `addr` and `wdata` stable from assertion until the cycle `done` is seen.
  - Keeping `req` high after `done` is a new request.
  - In a locked burst the new request continues the burst.
  - Unlocked, it re-arbitrates at lowest priority behind every other active requester.
- **Protocol violations:**
  - `req[owner]` dropping in ACCESS does not abort; the access completes and `done` still pulses.
  - `req` dropping in IDLE before it is sampled produces no transaction.
- **Fairness:** with all requesters active, each waits at most (NREQ-1) × (2·LOCKMAX+1) cycles between grants.

## Timing
- **Unlocked transaction:**
  - `req` sampled high on edge 0.
  - `gnt` high in cycles 1–2.
  - ACCESS in cycle 1; write commits at edge 2.
  - `done` and valid `rdata` in cycle 2.
  - IDLE in cycle 3; earliest next ACCESS is cycle 4.
- **Latency and throughput:**
  - `req` sampled to `done`: 2 cycles.
  - Unlocked: 3 cycles per transaction.
  - Locked burst: 2 cycles per transaction after the first (ACCESS/DONE alternating).
- **Asynchronous reset:**
  - Takes effect immediately.
  - If asserted during ACCESS, `mem_we` drops before the edge, so no write occurs.
  - Pending `done` is cleared.
  - After reset release, arbitration restarts from requester 0.
- **Simultaneous events:**
  - A `req` that rises in the DONE cycle of another owner is seen in the following IDLE.
  - `lock` is sampled only in DONE.

## Test plan
- **Single read:** `M[0x10]`=0xBEEF; req[1] read addr 0x10 → gnt=4'b0010 cycles 1–2, mem_re high cycle 1 only, done[1] cycle 2, rdata=0xBEEF from cycle 2.
- **Write then read:** req[2] write 0x3C←0x1234, then read 0x3C → first done cycle 2, mem_we high exactly one cycle; read returns 0x1234; rdata unchanged across the write.
- **Round-robin:** req[0..3] all held high from reset → grant order 0,1,2,3,0; each gnt lasts 2 cycles with one idle cycle between.
- **Locked burst:** LOCKMAX=4, req[3]+lock[3] held high, req[0] also high → requester 3 gets 4 transactions (done every 2 cycles), then releases; requester 0 granted next; no 5th transaction for 3.
- **Reset mid-write:** assert reset during ACCESS of a write to 0x20 (old value 0x0001) → mem_we, gnt and done go 0 immediately; M[0x20] remains 0x0001; after release with req[2] and req[0] high, requester 0 wins.
- **Dropped request:** req[1] deasserted during its ACCESS → done[1] still pulses in cycle 2, return to IDLE, no further grant to 1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and access sequencer for one shared single-port memory.
// Each grant runs ACCESS/DONE. A locked owner can keep the grant for up to LOCKMAX transactions.
module mem_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int LOCKMAX = 4
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ-1:0]   write_i,
    input  logic [NREQ-1:0]   lock_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ*DW-1:0] wdata_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [NREQ-1:0]   done_o,
    output logic [DW-1:0]     rdata_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [DW-1:0]     mem_wdata_o,
    input  logic [DW-1:0]     mem_rdata_i
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = (LOCKMAX > 1) ? $clog2(LOCKMAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_q, last_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic            win_valid;
    logic [OW-1:0]   win_idx;
    int              idx;

    // Scan last+1, last+2, ... so the previous owner ends up at lowest priority.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_q) + k) % NREQ;
            if (!win_valid && req_i[idx]) begin
                win_valid = 1'b1;
                win_idx   = OW'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        burst_d     = burst_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        rdata_d     = rdata_q;
        mem_re_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    owner_d          = win_idx;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    burst_d          = '0;
                    state_d          = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_addr_o  = addr_i[int'(owner_q)*AW +: AW];
                mem_wdata_o = wdata_i[int'(owner_q)*DW +: DW];
                mem_we_o    = write_i[owner_q];
                mem_re_o    = ~write_i[owner_q];
                if (!write_i[owner_q]) begin
                    rdata_d = mem_rdata_i;
                end
                done_d[owner_q] = 1'b1;
                state_d         = S_DONE;
            end
            S_DONE: begin
                if (lock_i[owner_q] && req_i[owner_q] && (burst_q < BW'(LOCKMAX-1))) begin
                    burst_d = burst_q + 1'b1;
                    state_d = S_ACCESS;
                end else begin
                    last_d  = owner_q;
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= OW'(NREQ-1);
            burst_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign done_o  = done_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, wr, lock, gnt, done;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [15:0] rdata, mem_wdata, mem_rdata;
    logic        mem_re, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.NREQ(4), .AW(8), .DW(16), .LOCKMAX(4)) dut (
        .clock_i     (clk),
        .reset_i     (rst),
        .req_i       (req),
        .write_i     (wr),
        .lock_i      (lock),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .gnt_o       (gnt),
        .done_o      (done),
        .rdata_o     (rdata),
        .mem_re_o    (mem_re),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic w, input logic [7:0] a, input logic [15:0] d);
        wr[i]            = w;
        addr[i*8 +: 8]   = a;
        wdata[i*16 +: 16] = d;
        req[i]           = 1'b1;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req = '0; wr = '0; lock = '0; addr = '0; wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'hBEEF;
        mem[8'h20] = 16'h0001;
        repeat (2) cyc();

        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_re_we", 32'({mem_re, mem_we}), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        rst = 1'b0;
        cyc();
        chk("idle_gnt", 32'(gnt), 32'h0);

        // single read by requester 1
        set_req(1, 1'b0, 8'h10, 16'h0);
        cyc();
        chk("rd_c1_gnt", 32'(gnt), 32'h2);
        chk("rd_c1_re", 32'(mem_re), 32'h1);
        chk("rd_c1_we", 32'(mem_we), 32'h0);
        chk("rd_c1_addr", 32'(mem_addr), 32'h10);
        chk("rd_c1_done", 32'(done), 32'h0);
        cyc();
        chk("rd_c2_gnt", 32'(gnt), 32'h2);
        chk("rd_c2_done", 32'(done), 32'h2);
        chk("rd_c2_re", 32'(mem_re), 32'h0);
        chk("rd_c2_rdata", 32'(rdata), 32'hBEEF);
        req = '0;
        cyc();
        chk("rd_c3_gnt", 32'(gnt), 32'h0);
        chk("rd_c3_done", 32'(done), 32'h0);
        chk("rd_c3_rdata", 32'(rdata), 32'hBEEF);

        // write then read by requester 2
        set_req(2, 1'b1, 8'h3C, 16'h1234);
        cyc();
        chk("wr_c1_gnt", 32'(gnt), 32'h4);
        chk("wr_c1_we", 32'(mem_we), 32'h1);
        chk("wr_c1_re", 32'(mem_re), 32'h0);
        chk("wr_c1_wdata", 32'(mem_wdata), 32'h1234);
        chk("wr_c1_addr", 32'(mem_addr), 32'h3C);
        cyc();
        chk("wr_c2_done", 32'(done), 32'h4);
        chk("wr_c2_we", 32'(mem_we), 32'h0);
        chk("wr_c2_rdata", 32'(rdata), 32'hBEEF);
        chk("wr_mem", 32'(mem[8'h3C]), 32'h1234);
        req = '0;
        cyc();
        chk("wr_c3_gnt", 32'(gnt), 32'h0);
        set_req(2, 1'b0, 8'h3C, 16'h0);
        cyc();
        chk("rb_c1_gnt", 32'(gnt), 32'h4);
        chk("rb_c1_re", 32'(mem_re), 32'h1);
        cyc();
        chk("rb_c2_done", 32'(done), 32'h4);
        chk("rb_c2_rdata", 32'(rdata), 32'h1234);
        req = '0;
        cyc();

        // round robin, all requesters active from reset
        rst = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'h10, 16'h0);
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("rr%0d_acc_gnt", k), 32'(gnt), 32'(1 << (k % 4)));
            cyc();
            chk($sformatf("rr%0d_done_gnt", k), 32'(gnt), 32'(1 << (k % 4)));
            chk($sformatf("rr%0d_done", k), 32'(done), 32'(1 << (k % 4)));
            cyc();
            chk($sformatf("rr%0d_idle_gnt", k), 32'(gnt), 32'h0);
        end
        req = '0;
        rst = 1'b1;
        cyc();

        // locked burst by requester 3, requester 0 waiting
        set_req(3, 1'b0, 8'h10, 16'h0);
        lock[3] = 1'b1;
        rst = 1'b0;
        cyc();
        chk("lk_c1_gnt", 32'(gnt), 32'h8);
        set_req(0, 1'b0, 8'h3C, 16'h0);
        n_done = 0;
        for (int c = 2; c <= 8; c++) begin
            cyc();
            if (done[3]) n_done++;
            chk($sformatf("lk_c%0d_gnt", c), 32'(gnt), 32'h8);
            chk($sformatf("lk_c%0d_done", c), 32'(done), (c % 2 == 0) ? 32'h8 : 32'h0);
        end
        chk("lk_count", 32'(n_done), 32'd4);
        cyc();
        chk("lk_c9_gnt", 32'(gnt), 32'h0);
        chk("lk_c9_done", 32'(done), 32'h0);
        cyc();
        chk("lk_c10_gnt", 32'(gnt), 32'h1);
        req = '0; lock = '0;
        cyc();
        chk("lk_c11_done", 32'(done), 32'h1);
        cyc();
        chk("lk_c12_gnt", 32'(gnt), 32'h0);

        // reset asserted in the middle of a write
        rst = 1'b1;
        set_req(2, 1'b1, 8'h20, 16'hDEAD);
        cyc();
        rst = 1'b0;
        cyc();
        chk("rw_c1_we", 32'(mem_we), 32'h1);
        chk("rw_c1_gnt", 32'(gnt), 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("rw_we_drop", 32'(mem_we), 32'h0);
        chk("rw_gnt_drop", 32'(gnt), 32'h0);
        chk("rw_done_drop", 32'(done), 32'h0);
        cyc();
        chk("rw_mem_kept", 32'(mem[8'h20]), 32'h0001);
        set_req(0, 1'b0, 8'h10, 16'h0);
        rst = 1'b0;
        cyc();
        chk("rw_restart_gnt", 32'(gnt), 32'h1);
        req = '0;
        rst = 1'b1;
        cyc();

        // requester drops req during its access
        set_req(1, 1'b0, 8'h3C, 16'h0);
        rst = 1'b0;
        cyc();
        chk("dr_c1_gnt", 32'(gnt), 32'h2);
        req = '0;
        cyc();
        chk("dr_c2_done", 32'(done), 32'h2);
        chk("dr_c2_rdata", 32'(rdata), 32'h1234);
        for (int c = 3; c <= 5; c++) begin
            cyc();
            chk($sformatf("dr_c%0d_gnt", c), 32'(gnt), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
